// File: rtl/vedm_pkg.sv
// Shared constants, types and helpers for the energy converter data path.
package vedm_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned GAIN_DEF   = 2;

  typedef logic [DATA_W_DEF-1:0] sample_t;

  // All-ones value of the given width, capped at 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned width);
    if (width >= 32) begin
      sat_max = '1;
    end else begin
      sat_max = (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/vedm_sat_scaler.sv
// Combinational gain stage: multiplies a sample by a fixed gain and either
// clamps or wraps the result back to the sample width.
module vedm_sat_scaler
  import vedm_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned GAIN     = GAIN_DEF,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] scaled
);

  // Four guard bits hold any product with a gain up to 15.
  localparam int unsigned          ProdW = DATA_W + 4;
  localparam logic [ProdW-1:0]     MaxP  = ProdW'(sat_max(DATA_W));
  localparam logic [DATA_W-1:0]    MaxO  = DATA_W'(sat_max(DATA_W));

  logic [ProdW-1:0] product;

  assign product = {4'b0000, sample} * ProdW'(GAIN);

  // Clamp on overflow when saturating, otherwise keep the low bits.
  always_comb begin
    scaled = product[DATA_W-1:0];
    if (SATURATE && (product > MaxP)) begin
      scaled = MaxO;
    end
  end

endmodule

// File: rtl/vedm_energy_converter.sv
// Converter tile data path: registers the raw sample, scales it, and
// registers the result. Two-cycle latency, one sample per clock.
module vedm_energy_converter
  import vedm_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned GAIN     = GAIN_DEF,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ui_in,
  output logic [DATA_W-1:0] uo_out
);

  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] result_q;

  // Stage 1 captures the raw sample, stage 2 the scaled result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      result_q <= '0;
    end else begin
      sample_q <= ui_in;
      result_q <= result_d;
    end
  end

  vedm_sat_scaler #(
    .DATA_W  (DATA_W),
    .GAIN    (GAIN),
    .SATURATE(SATURATE)
  ) u_scaler (
    .sample(sample_q),
    .scaled(result_d)
  );

  // Output comes straight from a flop, so it never glitches.
  assign uo_out = result_q;

endmodule

// File: tb/tb_vedm_energy_converter.sv
// Self-checking bench for the converter data path: four gain/saturation
// configurations share one stimulus stream and are compared against a
// sample-history reference model plus hand-written vectors.
module tb_vedm_energy_converter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] out_def, out_g2w, out_g3w, out_g3s;

  int checks = 0;
  int errors = 0;
  int hist[$];

  always #5 clk = ~clk;

  vedm_energy_converter u_def (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(out_def)
  );
  vedm_energy_converter #(.GAIN(2), .SATURATE(1'b0)) u_g2w (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(out_g2w)
  );
  vedm_energy_converter #(.GAIN(3), .SATURATE(1'b0)) u_g3w (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(out_g3w)
  );
  vedm_energy_converter #(.GAIN(3), .SATURATE(1'b1)) u_g3s (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(out_g3s)
  );

  typedef struct {
    int in;
    int e_def;
    int e_g2w;
    int e_g3w;
    int e_g3s;
  } vec_t;

  vec_t tbl[7];

  function automatic int ref_f(input int x, input int g, input bit sat);
    int p;
    p = x * g;
    if (sat && p > 255) return 255;
    return p % 256;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input int exp);
    checks++;
    if (act !== exp[7:0]) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Output after an edge is f(sample taken one edge earlier); zero before that.
  task automatic check_model(input string tag);
    int x;
    x = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
    chk({tag, "_def"}, out_def, ref_f(x, 2, 1'b1));
    chk({tag, "_g2w"}, out_g2w, ref_f(x, 2, 1'b0));
    chk({tag, "_g3w"}, out_g3w, ref_f(x, 3, 1'b0));
    chk({tag, "_g3s"}, out_g3s, ref_f(x, 3, 1'b1));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) hist.push_back(int'(ui_in));
    if (hist.size() > 4) void'(hist.pop_front());
    #1;
    check_model(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_def"}, out_def, 0);
    chk({tag, "_g2w"}, out_g2w, 0);
    chk({tag, "_g3w"}, out_g3w, 0);
    chk({tag, "_g3s"}, out_g3s, 0);
  endtask

  initial begin
    tbl[0] = '{0,   0,   0,   0,   0};
    tbl[1] = '{1,   2,   2,   3,   3};
    tbl[2] = '{127, 254, 254, 125, 255};
    tbl[3] = '{128, 255, 0,   128, 255};
    tbl[4] = '{200, 255, 144, 88,  255};
    tbl[5] = '{255, 255, 254, 253, 255};
    tbl[6] = '{100, 200, 200, 44,  255};

    // Reset held with a live input: outputs stay zero.
    ui_in = 8'h19;
    #1;
    chk_all_zero("rst_hold");
    for (int i = 0; i < 3; i++) tick("rst_clk");
    rst_n = 1'b1;
    tick("t1");
    chk("t1_edge1", out_def, 8'h00);
    tick("t1");
    chk("t1_edge2", out_def, 8'h32);

    // Input 0 then 25: result appears exactly two edges after the change.
    ui_in = 8'd0;
    tick("t2");
    tick("t2");
    ui_in = 8'd25;
    tick("t2");
    chk("t2_edge1", out_def, 0);
    tick("t2");
    chk("t2_edge2", out_def, 50);
    for (int i = 0; i < 3; i++) begin
      tick("t2_hold");
      chk("t2_hold", out_def, 50);
    end

    // 25 -> 45: old value held one edge, then new value, nothing in between.
    ui_in = 8'd45;
    tick("t3");
    chk("t3_edge1", out_def, 50);
    tick("t3");
    chk("t3_edge2", out_def, 90);
    tick("t3");
    chk("t3_hold", out_def, 90);

    // Asynchronous reset between edges clears outputs before the next edge.
    #3;
    rst_n = 1'b0;
    hist.delete();
    #1;
    chk_all_zero("async_rst");
    tick("t5_low");
    @(negedge clk);
    rst_n = 1'b1;
    ui_in = 8'd45;
    tick("t5");
    chk("t5_edge1", out_def, 0);
    tick("t5");
    chk("t5_edge2", out_def, 90);

    // Boundary sweep on consecutive cycles, checked one row behind.
    for (int i = 0; i <= 7; i++) begin
      ui_in = 8'(tbl[(i < 7) ? i : 6].in);
      tick("sweep");
      if (i >= 1) begin
        chk($sformatf("tbl%0d_def", i-1), out_def, tbl[i-1].e_def);
        chk($sformatf("tbl%0d_g2w", i-1), out_g2w, tbl[i-1].e_g2w);
        chk($sformatf("tbl%0d_g3w", i-1), out_g3w, tbl[i-1].e_g3w);
        chk($sformatf("tbl%0d_g3s", i-1), out_g3s, tbl[i-1].e_g3s);
      end
    end

    // Gain 3 with 100: wraps to 44, clamps to 255.
    ui_in = 8'd100;
    tick("t6");
    tick("t6");
    chk("t6_wrap", out_g3w, 44);
    chk("t6_sat", out_g3s, 255);

    // Random stream with one mid-stream reset pulse.
    for (int i = 0; i < 300; i++) begin
      ui_in = 8'($urandom_range(0, 255));
      if (i == 150) begin
        #3;
        rst_n = 1'b0;
        hist.delete();
        #1;
        chk_all_zero("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
